// File: rtl/vga_timing_if.sv
// Raster timing bundle from vga_timing to the colour stage.
// The master drives sync, valid qualifiers, coordinates, pulses and frame count.
interface vga_timing_if #(
   parameter int CNT_W = 11
);
   logic             hclk;
   logic             vclk;
   logic             dValid_h;
   logic             dValid_v;
   logic [CNT_W-1:0] pix_x;
   logic [CNT_W-1:0] pix_y;
   logic             line_start;
   logic             frame_start;
   logic [7:0]       frame_cnt;

   modport master (
      output hclk, vclk, dValid_h, dValid_v, pix_x, pix_y,
             line_start, frame_start, frame_cnt
   );

   modport slave (
      input  hclk, vclk, dValid_h, dValid_v, pix_x, pix_y,
             line_start, frame_start, frame_cnt
   );
endinterface

// File: rtl/vga_timing.sv
// VGA raster timing generator: horizontal/vertical FSMs, registered decoded outputs.
// Define VGA_TIMING_FRAME_CNT_EN to enable the 8-bit frame counter.
//
// state     | meaning
// H_ACT     | visible pixels of the line
// H_FRONT   | horizontal front porch
// H_SYNC_S  | horizontal sync pulse
// H_BACK    | horizontal back porch, last pixel wraps to x=0
// V_ACT     | visible lines of the frame
// V_FRONT   | vertical front porch
// V_SYNC_S  | vertical sync pulse
// V_BACK    | vertical back porch, last line wraps to y=0
module vga_timing #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic SYNC_POL = 1'b0,
   parameter int   CNT_W    = 11
) (
   input  logic         clk,
   input  logic         reset,
   vga_timing_if.master vga
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_ACT_LAST  = CNT_W'(H_ACTIVE - 1);
   localparam logic [CNT_W-1:0] H_FP_LAST   = CNT_W'(H_ACTIVE + H_FP - 1);
   localparam logic [CNT_W-1:0] H_SYNC_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_ACT_LAST  = CNT_W'(V_ACTIVE - 1);
   localparam logic [CNT_W-1:0] V_FP_LAST   = CNT_W'(V_ACTIVE + V_FP - 1);
   localparam logic [CNT_W-1:0] V_SYNC_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);

   typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNC_S, H_BACK} h_state_t;
   typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNC_S, V_BACK} v_state_t;

   h_state_t         h_state, h_state_nxt;
   v_state_t         v_state, v_state_nxt;
   logic [CNT_W-1:0] h_cnt, h_nxt;
   logic [CNT_W-1:0] v_cnt, v_nxt;
   logic             h_wrap;
   logic             hclk_nxt, vclk_nxt, dvh_nxt, dvv_nxt;
   logic             line_start_nxt, frame_start_nxt;

   logic             hclk_q, vclk_q, dvh_q, dvv_q;
   logic             line_start_q, frame_start_q;
   logic [CNT_W-1:0] pix_x_q, pix_y_q;

   always_comb begin
      h_state_nxt = h_state;
      v_state_nxt = v_state;
      h_wrap      = (h_cnt == H_LAST);
      h_nxt       = h_wrap ? '0 : h_cnt + CNT_W'(1);
      v_nxt       = v_cnt;

      case (h_state)
         H_ACT:    if (h_cnt == H_ACT_LAST)  h_state_nxt = H_FRONT;
         H_FRONT:  if (h_cnt == H_FP_LAST)   h_state_nxt = H_SYNC_S;
         H_SYNC_S: if (h_cnt == H_SYNC_LAST) h_state_nxt = H_BACK;
         H_BACK:   if (h_wrap)               h_state_nxt = H_ACT;
      endcase

      // Vertical position only moves on the last pixel of a line.
      if (h_wrap) begin
         v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
         case (v_state)
            V_ACT:    if (v_cnt == V_ACT_LAST)  v_state_nxt = V_FRONT;
            V_FRONT:  if (v_cnt == V_FP_LAST)   v_state_nxt = V_SYNC_S;
            V_SYNC_S: if (v_cnt == V_SYNC_LAST) v_state_nxt = V_BACK;
            V_BACK:   if (v_cnt == V_LAST)      v_state_nxt = V_ACT;
         endcase
      end

      hclk_nxt        = (h_state_nxt == H_SYNC_S) ? SYNC_POL : ~SYNC_POL;
      vclk_nxt        = (v_state_nxt == V_SYNC_S) ? SYNC_POL : ~SYNC_POL;
      dvh_nxt         = (h_state_nxt == H_ACT);
      dvv_nxt         = (v_state_nxt == V_ACT);
      line_start_nxt  = (h_nxt == '0);
      frame_start_nxt = (h_nxt == '0) && (v_nxt == '0);
   end

   // Position parks on the last pixel of the frame so the first edge presents (0,0).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_state       <= H_BACK;
         v_state       <= V_BACK;
         h_cnt         <= H_LAST;
         v_cnt         <= V_LAST;
         hclk_q        <= ~SYNC_POL;
         vclk_q        <= ~SYNC_POL;
         dvh_q         <= 1'b0;
         dvv_q         <= 1'b0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         h_state       <= h_state_nxt;
         v_state       <= v_state_nxt;
         h_cnt         <= h_nxt;
         v_cnt         <= v_nxt;
         hclk_q        <= hclk_nxt;
         vclk_q        <= vclk_nxt;
         dvh_q         <= dvh_nxt;
         dvv_q         <= dvv_nxt;
         pix_x_q       <= h_nxt;
         pix_y_q       <= v_nxt;
         line_start_q  <= line_start_nxt;
         frame_start_q <= frame_start_nxt;
      end
   end

   assign vga.hclk        = hclk_q;
   assign vga.vclk        = vclk_q;
   assign vga.dValid_h    = dvh_q;
   assign vga.dValid_v    = dvv_q;
   assign vga.pix_x       = pix_x_q;
   assign vga.pix_y       = pix_y_q;
   assign vga.line_start  = line_start_q;
   assign vga.frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [7:0] frame_cnt_q;

   // Starts at FF so the first frame after reset reads 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                frame_cnt_q <= 8'hFF;
      else if (frame_start_nxt) frame_cnt_q <= frame_cnt_q + 8'd1;
   end

   assign vga.frame_cnt = frame_cnt_q;
`else
   assign vga.frame_cnt = 8'h00;
`endif

endmodule

// File: doc/vga_timing.md
# vga_timing

Raster timing generator for the VGA output path. Runs on the 25 MHz pixel clock. Produces horizontal and vertical sync (`hclk`/`vclk`), the per-axis data-valid qualifiers `dValid_h`/`dValid_v`, and pixel coordinates. The colour stage downstream consumes these outputs and gates its 4-bit R/G/B with `dValid_h & dValid_v`.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_POL`, 0, asserted level of `hclk`/`vclk` (0 = active-low)
- `CNT_W`, 11, width of internal counters and coordinate outputs
- `clk` input 1: pixel clock (25 MHz); all logic on rising edge
- `reset` input 1: asynchronous, active-high; clears all state immediately
- `hclk` output 1: horizontal sync, level `SYNC_POL` during H sync phase
- `vclk` output 1: vertical sync, level `SYNC_POL` during V sync phase
- `dValid_h` output 1: high while horizontal position is in active region
- `dValid_v` output 1: high while vertical position is in active region
- `pix_x` output CNT_W: current horizontal position, 0..H_TOTAL-1
- `pix_y` output CNT_W: current vertical position, 0..V_TOTAL-1
- `line_start` output 1: one-cycle pulse at `pix_x`==0
- `frame_start` output 1: one-cycle pulse at `pix_x`==0 and `pix_y`==0
- `frame_cnt` output 8: frame counter (see Configuration)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Every parameter must be ≥1.
- Horizontal FSM has four states: H_ACT, H_FRONT, H_SYNC_S, H_BACK.
  - H_ACT covers x 0..639, H_FRONT 640..655, H_SYNC_S 656..751, H_BACK 752..799.
  - H_BACK at x=H_TOTAL-1 goes to H_ACT with x=0.
- Vertical FSM has the same four states, indexed by y, with boundaries at 480, 490, 492, 525.
  - It advances only on the cycle the horizontal counter wraps.
  - y wraps V_TOTAL-1 → 0.
- Output decoding from the position being presented:
  - `dValid_h` = (H state == H_ACT); `dValid_v` = (V state == V_ACT).
  - `hclk` = SYNC_POL in H_SYNC_S, ~SYNC_POL otherwise. `vclk` follows the same rule in V_SYNC_S.
  - `vclk` transitions coincide with x=0.
- All outputs are registered. The next position is computed combinationally, then position and all decoded outputs are loaded on the same edge, so every output describes the same pixel.
- Arithmetic is unsigned CNT_W. Counters never exceed TOTAL-1; no overflow is possible for CNT_W=11.
- Reset values:
  - Internal position is (H_TOTAL-1, V_TOTAL-1), so the first post-reset edge presents (0,0).
  - `hclk` = `vclk` = ~SYNC_POL.
  - `dValid_h` = `dValid_v` = 0, `pix_x` = `pix_y` = 0, `line_start` = `frame_start` = 0, `frame_cnt` = 8'hFF.
- Reset asserted mid-frame: outputs go to reset values asynchronously. After release, the raster restarts from (0,0) and no partial line is emitted.

## Timing
- First rising edge after `reset` release: `pix_x`=0, `pix_y`=0, `dValid_h`=`dValid_v`=1, `line_start`=`frame_start`=1.
- Position advances by one pixel per `clk`. Latency is zero cycles from position to decoded outputs, since all are registered together.
- `hclk` is asserted for exactly 96 consecutive cycles, beginning 656 cycles after `line_start`.
- `vclk` is asserted for exactly 2×800 = 1600 cycles, beginning at the x=0 edge of line 490.
- Line period is 800 cycles; frame period is 420000 cycles.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined: `frame_cnt` increments, wrapping modulo 256, on the same edge `frame_start` asserts. The first frame after reset reads 0, and 255 wraps to 0.
- Not defined: `frame_cnt` is tied to 8'h00 and no counter flops are synthesized. All other behaviour is identical.

## Test plan
- Hold `reset` 5 cycles, then release → during reset all outputs equal the reset values. First edge shows (0,0), `frame_start`=1, `dValid_h`=`dValid_v`=1.
- Run one line → `dValid_h` high for exactly 640 cycles, then `hclk`=0 for cycles 656..751, `line_start` again at cycle 800.
- Run one full frame → count of cycles with `dValid_h & dValid_v` = 307200. `vclk` low only for lines 490–491. `frame_start` recurs at cycle 420000.
- Assert `reset` asynchronously at (x=300, y=200), mid-cycle → outputs clear before the next edge. After release, the raster resumes at (0,0).
- With `VGA_TIMING_FRAME_CNT_EN` defined, run 257 frames → `frame_cnt` reads 0,1,…,255,0. Without the macro → `frame_cnt` stays 0 throughout.
- Override parameters to H 8/2/3/2 and V 4/1/1/1 → H_TOTAL=15, V_TOTAL=7. `hclk` asserted at x=10..12, `vclk` asserted at y=5, wrap occurs at (14,6).
